// File: rtl/vinstru_run_sequencer.sv
// vinstru_run_sequencer: one start pulse resets vinstru, then runs num_runs run/done handshakes
// with a programmable gap, per-run timeout, abort, run counting and a completion pulse.
module vinstru_run_sequencer #(
  parameter int RST_CYCLES = 8,
  parameter int CNT_W      = 16
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_runs,
  input  logic [31:0]      run_gap,
  input  logic [31:0]      run_timeout,
  output logic             vinstru_reset,
  output logic             vinstru_run,
  input  logic             vinstru_done,
  output logic             busy,
  output logic [CNT_W-1:0] runs_done,
  output logic             timeout_err,
  output logic             seq_done
);
  typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_CLR, S_GAP, S_FIN} state_t;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_num;
  logic [31:0]      r_gap, r_tmo, r_cnt;
  logic             w_start, w_done_hit, w_tmo_hit;
  always_comb begin
    w_next     = r_state;
    w_start    = r_state == S_IDLE && start && !abort;
    w_done_hit = r_state == S_RUN && vinstru_done && !abort;
    w_tmo_hit  = r_state == S_RUN && !vinstru_done && !abort && r_tmo != 32'd0 && r_cnt == r_tmo - 32'd1;
    case (r_state)
      S_IDLE:  w_next = w_start ? S_RST : S_IDLE;
      S_RST:   w_next = r_cnt == 32'(RST_CYCLES - 1) ? S_RUN : S_RST;
      S_RUN:   w_next = vinstru_done || w_tmo_hit ? S_CLR : S_RUN;
      S_CLR:   w_next = vinstru_done ? S_CLR : (r_num != '0 && runs_done == r_num) ? S_FIN : (r_gap == 32'd0) ? S_RUN : S_GAP;
      S_GAP:   w_next = r_cnt == r_gap - 32'd1 ? S_RUN : S_GAP;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort && r_state != S_IDLE) w_next = S_IDLE;
  end
  // r_cnt restarts on every state change, so it times RST, RUN and GAP alike
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_num         <= '0;
      r_gap         <= '0;
      r_tmo         <= '0;
      runs_done     <= '0;
      timeout_err   <= 1'b0;
      vinstru_reset <= 1'b0;
      vinstru_run   <= 1'b0;
      busy          <= 1'b0;
      seq_done      <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_cnt         <= w_next != r_state ? 32'd0 : r_cnt + 32'd1;
      vinstru_reset <= w_next == S_RST;
      vinstru_run   <= w_next == S_RUN;
      busy          <= w_next != S_IDLE;
      seq_done      <= w_next == S_FIN;
      if (w_start) begin
        r_num       <= num_runs;
        r_gap       <= run_gap;
        r_tmo       <= run_timeout;
        runs_done   <= '0;
        timeout_err <= 1'b0;
      end
      if (w_done_hit) runs_done <= runs_done + 1'b1;
      if (w_tmo_hit) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vinstru_run_sequencer.sv
// tb_vinstru_run_sequencer: randomized and directed sequences against a vinstru done model,
// checked with cycle counts derived from the run/gap/reset timing rules.
module tb_vinstru_run_sequencer;
  localparam int RST = 8;
  logic        clk = 1'b0;
  logic        rstn, start, abort, done;
  logic [15:0] num_runs, runs_done;
  logic [31:0] gap, tmo;
  logic        v_rst, v_run, busy, terr, sdone;
  int          n_cmp = 0, n_bad = 0;
  int          rise, fall, skip_n;
  logic        mon_clr;
  int          m_hi, m_lo, m_skip;
  logic        m_prun;
  int          rises, sd_cnt, busy_cyc, rst_cyc, lo_cyc, hi_cyc, bad_fin, lead;
  logic        p_run;
  int          gaps[$], highs[$];

  vinstru_run_sequencer dut (
    .axi_aclk(clk), .axi_aresetn(rstn), .start(start), .abort(abort),
    .num_runs(num_runs), .run_gap(gap), .run_timeout(tmo),
    .vinstru_reset(v_rst), .vinstru_run(v_run), .vinstru_done(done),
    .busy(busy), .runs_done(runs_done), .timeout_err(terr), .seq_done(sdone)
  );

  always #5 clk = ~clk;

  // vinstru model: done rises after run has been high `rise` edges, falls after run low `fall` edges;
  // the first skip_n runs never complete
  always @(posedge clk) begin
    if (mon_clr) begin
      m_skip <= skip_n; m_hi <= 0; m_lo <= 0; m_prun <= 1'b0; done <= 1'b0;
    end else begin
      m_prun <= v_run;
      if (v_run) begin
        m_lo <= 0; m_hi <= m_hi + 1;
        if (m_skip == 0 && m_hi + 1 >= rise) done <= 1'b1;
      end else begin
        m_hi <= 0; m_lo <= m_lo + 1;
        if (m_lo + 1 >= fall) done <= 1'b0;
        if (m_prun && m_skip > 0) m_skip <= m_skip - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_clr) begin
      rises = 0; sd_cnt = 0; busy_cyc = 0; rst_cyc = 0; lo_cyc = 0; hi_cyc = 0;
      bad_fin = 0; lead = -1; p_run = 1'b0; gaps.delete(); highs.delete();
    end else begin
      busy_cyc += int'(busy); rst_cyc += int'(v_rst); sd_cnt += int'(sdone);
      if (sdone && !busy) bad_fin++;
      if (v_run && !p_run) begin
        if (rises > 0) gaps.push_back(lo_cyc); else lead = lo_cyc;
        rises++;
      end
      if (!v_run && p_run) highs.push_back(hi_cyc);
      lo_cyc = v_run ? 0 : lo_cyc + 1;
      hi_cyc = v_run ? hi_cyc + 1 : 0;
      p_run = v_run;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1; @(negedge clk); tick(); mon_clr = 1'b0;
  endtask

  task automatic begin_seq(input int n, input int g, input int t, input int ri, input int fa, input int sk);
    num_runs = 16'(n); gap = 32'(g); tmo = 32'(t); rise = ri; fall = fa; skip_n = sk;
    clr_mon();
    start = 1'b1; tick(); start = 1'b0;
    num_runs = 16'd1; gap = 32'd0; tmo = 32'd1;
  endtask

  task automatic run_seq(input int n, input int g, input int t, input int ri, input int fa, input int sk, output bit ok);
    begin_seq(n, g, t, ri, fa, sk);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b1;
    repeat (3) tick();
    n_cmp++; if (v_rst !== 1'b0) begin n_bad++; $display("FAIL rst_vreset: got %b want 0", v_rst); end
    n_cmp++; if (v_run !== 1'b0) begin n_bad++; $display("FAIL rst_vrun: got %b want 0", v_run); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (runs_done !== 16'd0) begin n_bad++; $display("FAIL rst_runs_done: got %0d want 0", runs_done); end
    n_cmp++; if (terr !== 1'b0) begin n_bad++; $display("FAIL rst_timeout_err: got %b want 0", terr); end
    n_cmp++; if (sdone !== 1'b0) begin n_bad++; $display("FAIL rst_seq_done: got %b want 0", sdone); end
    start = 1'b0; rstn = 1'b1; tick();
  endtask

  task automatic test_sequence();
    bit ok;
    run_seq(3, 10, 0, 20, 2, 0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL t1_finish: busy still %b want 0", busy); end
    n_cmp++; if (rises != 3) begin n_bad++; $display("FAIL t1_pulses: got %0d want 3", rises); end
    n_cmp++; if (lead != RST + 1) begin n_bad++; $display("FAIL t1_latency: got %0d want %0d", lead, RST + 1); end
    n_cmp++; if (rst_cyc != RST) begin n_bad++; $display("FAIL t1_reset_len: got %0d want %0d", rst_cyc, RST); end
    for (int i = 0; i < gaps.size(); i++) begin
      n_cmp++; if (gaps[i] != 13) begin n_bad++; $display("FAIL t1_gap%0d: got %0d want 13", i, gaps[i]); end
    end
    n_cmp++; if (highs.size() < 1 || highs[0] != 21) begin n_bad++; $display("FAIL t1_run_len: got %0d want 21", highs.size() > 0 ? highs[0] : -1); end
    n_cmp++; if (runs_done !== 16'd3) begin n_bad++; $display("FAIL t1_runs_done: got %0d want 3", runs_done); end
    n_cmp++; if (sd_cnt != 1) begin n_bad++; $display("FAIL t1_seq_done: got %0d want 1", sd_cnt); end
    n_cmp++; if (bad_fin != 0) begin n_bad++; $display("FAIL t1_busy_with_fin: got %0d want 0", bad_fin); end
    n_cmp++; if (busy_cyc != RST + 3 * 21 + 3 * 3 + 2 * 10 + 1) begin n_bad++; $display("FAIL t1_busy_len: got %0d want %0d", busy_cyc, RST + 93); end
    n_cmp++; if (terr !== 1'b0) begin n_bad++; $display("FAIL t1_timeout_err: got %b want 0", terr); end
  endtask

  task automatic test_timeout();
    bit ok;
    run_seq(2, 4, 50, 5, 2, 1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL t2_finish: busy still %b want 0", busy); end
    n_cmp++; if (rises != 3) begin n_bad++; $display("FAIL t2_pulses: got %0d want 3", rises); end
    n_cmp++; if (highs.size() < 1 || highs[0] != 50) begin n_bad++; $display("FAIL t2_timeout_len: got %0d want 50", highs.size() > 0 ? highs[0] : -1); end
    n_cmp++; if (gaps.size() < 1 || gaps[0] != 5) begin n_bad++; $display("FAIL t2_gap_after_timeout: got %0d want 5", gaps.size() > 0 ? gaps[0] : -1); end
    n_cmp++; if (runs_done !== 16'd2) begin n_bad++; $display("FAIL t2_runs_done: got %0d want 2", runs_done); end
    n_cmp++; if (terr !== 1'b1) begin n_bad++; $display("FAIL t2_timeout_err: got %b want 1", terr); end
    n_cmp++; if (sd_cnt != 1) begin n_bad++; $display("FAIL t2_seq_done: got %0d want 1", sd_cnt); end
  endtask

  task automatic test_continuous_abort();
    repeat (3) tick();
    n_cmp++; if (terr !== 1'b1) begin n_bad++; $display("FAIL t3_err_sticky: got %b want 1", terr); end
    begin_seq(0, 0, 0, 3, 1, 0);
    n_cmp++; if (terr !== 1'b0) begin n_bad++; $display("FAIL t3_err_cleared: got %b want 0", terr); end
    n_cmp++; if (runs_done !== 16'd0) begin n_bad++; $display("FAIL t3_runs_cleared: got %0d want 0", runs_done); end
    for (int i = 0; i < 2000 && runs_done != 16'd5; i++) tick();
    n_cmp++; if (runs_done !== 16'd5) begin n_bad++; $display("FAIL t3_reach5: got %0d want 5", runs_done); end
    abort = 1'b1; tick(); abort = 1'b0;
    n_cmp++; if (v_run !== 1'b0 || v_rst !== 1'b0) begin n_bad++; $display("FAIL t3_abort_outs: got run=%b rst=%b want 0 0", v_run, v_rst); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t3_abort_busy: got %b want 0", busy); end
    tick();
    n_cmp++; if (runs_done !== 16'd5) begin n_bad++; $display("FAIL t3_runs_held: got %0d want 5", runs_done); end
    n_cmp++; if (sd_cnt != 0) begin n_bad++; $display("FAIL t3_no_seq_done: got %0d want 0", sd_cnt); end
    n_cmp++; if (rises != 5) begin n_bad++; $display("FAIL t3_pulses: got %0d want 5", rises); end
    n_cmp++; if (gaps.size() < 1 || gaps[0] != 2) begin n_bad++; $display("FAIL t3_b2b_gap: got %0d want 2", gaps.size() > 0 ? gaps[0] : -1); end
  endtask

  task automatic test_start_abort();
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || v_rst !== 1'b0) begin n_bad++; $display("FAIL t4_abort_wins: got busy=%b rst=%b want 0 0", busy, v_rst); end
    tick();
    n_cmp++; if (busy !== 1'b0 || runs_done !== 16'd5) begin n_bad++; $display("FAIL t4_idle_held: got busy=%b runs=%0d want 0 5", busy, runs_done); end
    begin_seq(2, 3, 0, 6, 1, 0);
    for (int i = 0; i < 500 && !(runs_done == 16'd1 && v_run); i++) tick();
    n_cmp++; if (runs_done !== 16'd1 || v_run !== 1'b1) begin n_bad++; $display("FAIL t4_second_run: got runs=%0d run=%b want 1 1", runs_done, v_run); end
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if (runs_done !== 16'd1 || v_rst !== 1'b0 || v_run !== 1'b1) begin n_bad++; $display("FAIL t4_start_busy: got runs=%0d rst=%b run=%b want 1 0 1", runs_done, v_rst, v_run); end
    for (int i = 0; i < 500 && busy; i++) tick();
    n_cmp++; if (runs_done !== 16'd2 || sd_cnt != 1) begin n_bad++; $display("FAIL t4_end: got runs=%0d sd=%0d want 2 1", runs_done, sd_cnt); end
  endtask

  task automatic test_reset_gap();
    bit ok;
    begin_seq(3, 20, 0, 3, 2, 0);
    for (int i = 0; i < 500 && runs_done != 16'd1; i++) tick();
    repeat (5) tick();
    n_cmp++; if (v_run !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL t5_in_gap: got run=%b busy=%b want 0 1", v_run, busy); end
    rstn = 1'b0; tick();
    n_cmp++; if ({v_rst, v_run, busy, terr, sdone} !== 5'b0 || runs_done !== 16'd0) begin n_bad++; $display("FAIL t5_reset_outs: got %b runs=%0d want 00000 0", {v_rst, v_run, busy, terr, sdone}, runs_done); end
    rstn = 1'b1; repeat (4) tick();
    run_seq(1, 0, 0, 4, 2, 0, ok);
    n_cmp++; if (!ok || runs_done !== 16'd1 || sd_cnt != 1) begin n_bad++; $display("FAIL t5_restart: got ok=%0d runs=%0d sd=%0d want 1 1 1", ok, runs_done, sd_cnt); end
    n_cmp++; if (busy_cyc != RST + 5 + 3 + 1) begin n_bad++; $display("FAIL t5_busy_len: got %0d want %0d", busy_cyc, RST + 9); end
  endtask

  task automatic test_coincide();
    bit ok;
    run_seq(1, 0, 20, 19, 2, 0, ok);
    n_cmp++; if (!ok || runs_done !== 16'd1) begin n_bad++; $display("FAIL t6_counted: got ok=%0d runs=%0d want 1 1", ok, runs_done); end
    n_cmp++; if (terr !== 1'b0) begin n_bad++; $display("FAIL t6_no_err: got %b want 0", terr); end
    n_cmp++; if (highs.size() < 1 || highs[0] != 20) begin n_bad++; $display("FAIL t6_run_len: got %0d want 20", highs.size() > 0 ? highs[0] : -1); end
  endtask

  task automatic test_random();
    bit ok;
    int n, g, t, ri, fa;
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 4); g = $urandom_range(0, 12); ri = $urandom_range(1, 15); fa = $urandom_range(1, 4);
      t = $urandom_range(0, 1) == 0 ? 0 : ri + 1 + $urandom_range(0, 5);
      run_seq(n, g, t, ri, fa, 0, ok);
      n_cmp++; if (!ok || rises != n) begin n_bad++; $display("FAIL rnd%0d_pulses: got ok=%0d pulses=%0d want 1 %0d", k, ok, rises, n); end
      n_cmp++; if (runs_done !== 16'(n) || sd_cnt != 1 || terr !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_result: got runs=%0d sd=%0d err=%b want %0d 1 0", k, runs_done, sd_cnt, terr, n); end
      n_cmp++; if (busy_cyc != RST + n * (ri + 1) + n * (fa + 1) + (n - 1) * g + 1) begin n_bad++; $display("FAIL rnd%0d_busy_len: got %0d want %0d", k, busy_cyc, RST + n * (ri + fa + 2) + (n - 1) * g + 1); end
      n_cmp++; if (lead != RST + 1) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", k, lead, RST + 1); end
      for (int i = 0; i < gaps.size(); i++) begin
        n_cmp++; if (gaps[i] != g + fa + 1) begin n_bad++; $display("FAIL rnd%0d_gap%0d: got %0d want %0d", k, i, gaps[i], g + fa + 1); end
      end
      for (int i = 0; i < highs.size(); i++) begin
        n_cmp++; if (highs[i] != ri + 1) begin n_bad++; $display("FAIL rnd%0d_high%0d: got %0d want %0d", k, i, highs[i], ri + 1); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; mon_clr = 1'b1;
    num_runs = '0; gap = '0; tmo = '0; rise = 1; fall = 2; skip_n = 0;
    tick(); tick(); mon_clr = 1'b0;
    test_reset();
    test_sequence();
    test_timeout();
    test_continuous_abort();
    test_start_abort();
    test_reset_gap();
    test_coincide();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
